// File: rtl/io_input_reader.sv
`default_nettype none
// ============================================================================
// Module   : io_input_reader
// Brief    : Memory-mapped input block: synchronises and debounces two
//            switch banks and four push keys, latches key-press events and
//            returns the selected port on a CPU I/O read.
// Revision : 1.0 - initial release
// ============================================================================

// Per-channel debouncer: stable follows sync only after DEBOUNCE_CYCLES
// consecutive cycles of disagreement; o_rise flags bits going 0->1 that edge.
module io_input_debounce #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_sync,
    output logic [WIDTH-1:0] o_stable,
    output logic [WIDTH-1:0] o_rise
);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_stable;
    logic             w_differ;
    logic             w_done;

    assign w_differ = (i_sync != r_stable);
    assign w_done   = w_differ && (r_cnt == c_CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_stable <= '0;
        end else if (!w_differ) begin
            r_cnt <= '0;
        end else if (w_done) begin
            r_stable <= i_sync;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = w_done ? (i_sync & ~r_stable) : '0;
endmodule

module io_input_reader #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic        io_clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        read_io_enable,
    input  logic [4:0]  in_port0,
    input  logic [4:0]  in_port1,
    input  logic [3:0]  key_in,
    output logic [31:0] io_read_data
);
    localparam logic [5:0] c_ADDR_PORT0 = 6'b100000;
    localparam logic [5:0] c_ADDR_PORT1 = 6'b100001;
    localparam logic [5:0] c_ADDR_KEYS  = 6'b100010;

    logic [13:0] r_sync1;
    logic [13:0] r_sync2;
    logic [4:0]  w_stable0;
    logic [4:0]  w_stable1;
    logic [4:0]  w_rise0;
    logic [4:0]  w_rise1;
    logic [3:0]  w_key_level;
    logic [3:0]  w_key_rise;
    logic [3:0]  r_key_evt;
    logic        w_read_keys;
    logic        w_unused;

    // Bit layout of the synchroniser: {key_in, in_port1, in_port0}
    always_ff @(posedge io_clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {key_in, in_port1, in_port0};
            r_sync2 <= r_sync1;
        end
    end

    io_input_debounce #(
        .WIDTH(5), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
    ) u_port0 (
        .clk(io_clk), .rst(reset), .i_sync(r_sync2[4:0]),
        .o_stable(w_stable0), .o_rise(w_rise0)
    );

    io_input_debounce #(
        .WIDTH(5), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
    ) u_port1 (
        .clk(io_clk), .rst(reset), .i_sync(r_sync2[9:5]),
        .o_stable(w_stable1), .o_rise(w_rise1)
    );

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key
            io_input_debounce #(
                .WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
            ) u_key (
                .clk(io_clk), .rst(reset), .i_sync(r_sync2[10+gi]),
                .o_stable(w_key_level[gi]), .o_rise(w_key_rise[gi])
            );
        end
    endgenerate

    assign w_read_keys = read_io_enable && (addr[7:2] == c_ADDR_KEYS);

    // A press landing on the clearing read still survives: set wins.
    always_ff @(posedge io_clk) begin
        if (reset) begin
            r_key_evt <= '0;
        end else begin
            r_key_evt <= (w_read_keys ? 4'b0000 : r_key_evt) | w_key_rise;
        end
    end

    always_comb begin
        io_read_data = 32'd0;
        if (read_io_enable) begin
            case (addr[7:2])
                c_ADDR_PORT0: io_read_data = {27'd0, w_stable0};
                c_ADDR_PORT1: io_read_data = {27'd0, w_stable1};
                c_ADDR_KEYS:  io_read_data = {24'd0, r_key_evt, w_key_level};
                default:      io_read_data = 32'd0;
            endcase
        end
    end

    assign w_unused = ^{addr[31:8], addr[1:0], w_rise0, w_rise1};
endmodule
`default_nettype wire
